fluxo_dados_quiz: RTL and testbench

- Datapath partner of the quiz control unit: consumes its zera*/conta*/registra* strobes and returns the status flags jogada_feita, botaoIgualMemoria and rodadaIgualFinal.
- Holds the round, hit and timer counters, the player-answer register R and the expected-answer register M.
- Reads expected answers from a fixed answer ROM.
- Sits between the control FSM and the board I/O (4 answer buttons, displays/LEDs for debug).

---
 rtl/quiz_pkg.sv | 27 ++
 rtl/rom_respostas.sv | 21 ++
 rtl/fluxo_dados_quiz.sv | 127 ++++++++++++
 tb/tb_fluxo_dados_quiz.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz datapath: answer ROM geometry and the
// one-hot answer codes for the four buttons (A..D).
package quiz_pkg;

    localparam int unsigned ROM_DEPTH = 16;
    localparam int unsigned RESP_W    = 4;

    typedef logic [RESP_W-1:0] resp_t;

    localparam resp_t RESP_A = 4'b0001;
    localparam resp_t RESP_B = 4'b0010;
    localparam resp_t RESP_C = 4'b0100;
    localparam resp_t RESP_D = 4'b1000;

    // Answer pattern cycles A, B, C, D starting at address 0.
    function automatic resp_t resp_for(input logic [3:0] addr);
        resp_t r;
        unique case (addr[1:0])
            2'd0:    r = RESP_A;
            2'd1:    r = RESP_B;
            2'd2:    r = RESP_C;
            default: r = RESP_D;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rom_respostas.sv
// Answer ROM: combinational 16x4 lookup of the expected answer per question.
// Ports:
//   addr_i  question index (round counter value)
//   resp_o  one-hot expected answer, 0000 for addresses past the last question
module rom_respostas
    import quiz_pkg::*;
#(
    parameter int unsigned N_RODADAS = 10
) (
    input  logic [3:0] addr_i,
    output resp_t      resp_o
);

    always_comb begin
        resp_o = '0;
        if (32'(addr_i) < N_RODADAS) begin
            resp_o = resp_for(addr_i);
        end
    end

endmodule

// File: rtl/fluxo_dados_quiz.sv
// Quiz datapath: round/hit/timer counters, player answer R, expected answer M,
// button synchronizer with press detection, and status flags for the control FSM.
// Ports:
//   clock, reset       clock (rising edge) and asynchronous active-low reset
//   botoes             raw answer buttons (asynchronous, active-high)
//   zera*/conta*/registra*  control strobes; a clear always wins on its unit
//   jogada_feita       one-cycle pulse per new button press
//   botaoIgualMemoria  R == M
//   rodadaIgualFinal   round counter == N_RODADAS
//   timeout            timer at its terminal count
//   db_*               debug views of rodada, acertos, R and M
module fluxo_dados_quiz
    import quiz_pkg::*;
#(
    parameter int unsigned N_RODADAS = 10,
    parameter int unsigned T_MAX     = 50000000,
    parameter int unsigned TW        = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       zeraR,
    input  logic       zeraRod,
    input  logic       zeraA,
    input  logic       zeraM,
    input  logic       zeraI,
    input  logic       registraR,
    input  logic       registraM,
    input  logic       contaRod,
    input  logic       contaA,
    input  logic       contaI,
    output logic       jogada_feita,
    output logic       botaoIgualMemoria,
    output logic       rodadaIgualFinal,
    output logic       timeout,
    output logic [3:0] db_rodada,
    output logic [3:0] db_acertos,
    output logic [3:0] db_jogada,
    output logic [3:0] db_memoria
);

    localparam logic [TW-1:0] TMR_LAST = TW'(T_MAX - 1);

    logic [3:0]    sync1_q, sync2_q, prev_q;
    logic [3:0]    jog_q, jog_d;
    logic          jf_q, jf_d;
    resp_t         r_q, r_d;
    resp_t         m_q, m_d;
    logic [3:0]    rod_q, rod_d;
    logic [3:0]    acc_q, acc_d;
    logic [TW-1:0] tmr_q, tmr_d;
    resp_t         rom_resp;
    logic          press;

    rom_respostas #(
        .N_RODADAS(N_RODADAS)
    ) u_rom (
        .addr_i(rod_q),
        .resp_o(rom_resp)
    );

    // Rising edge of "any button down"; a held button cannot retrigger.
    assign press = (|sync2_q) & ~(|prev_q);

    always_comb begin
        jf_d  = press;
        jog_d = press ? sync2_q : jog_q;

        r_d = r_q;
        if (zeraR)          r_d = '0;
        else if (registraR) r_d = jog_q;

        // ROM is addressed by the pre-increment round value.
        m_d = m_q;
        if (zeraM)          m_d = '0;
        else if (registraM) m_d = rom_resp;

        rod_d = rod_q;
        if (zeraRod)       rod_d = '0;
        else if (contaRod) rod_d = rod_q + 4'd1;

        acc_d = acc_q;
        if (zeraA)                        acc_d = '0;
        else if (contaA && acc_q != 4'hF) acc_d = acc_q + 4'd1;

        // Saturate so a continuously asserted contaI never wraps.
        tmr_d = tmr_q;
        if (zeraI)                          tmr_d = '0;
        else if (contaI && tmr_q != TMR_LAST) tmr_d = tmr_q + TW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            jog_q   <= '0;
            jf_q    <= 1'b0;
            r_q     <= '0;
            m_q     <= '0;
            rod_q   <= '0;
            acc_q   <= '0;
            tmr_q   <= '0;
        end else begin
            sync1_q <= botoes;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            jog_q   <= jog_d;
            jf_q    <= jf_d;
            r_q     <= r_d;
            m_q     <= m_d;
            rod_q   <= rod_d;
            acc_q   <= acc_d;
            tmr_q   <= tmr_d;
        end
    end

    assign jogada_feita      = jf_q;
    assign botaoIgualMemoria = (r_q == m_q);
    assign rodadaIgualFinal  = ({1'b0, rod_q} == 5'(N_RODADAS));
    assign timeout           = (tmr_q == TMR_LAST);
    assign db_rodada         = rod_q;
    assign db_acertos        = acc_q;
    assign db_jogada         = r_q;
    assign db_memoria        = m_q;

endmodule

// File: tb/tb_fluxo_dados_quiz.sv
module tb_fluxo_dados_quiz;

    localparam int N_RODADAS = 10;
    localparam int T_MAX     = 8;
    localparam int TW        = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       zeraR, zeraRod, zeraA, zeraM, zeraI;
    logic       registraR, registraM, contaRod, contaA, contaI;
    logic       jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout;
    logic [3:0] db_rodada, db_acertos, db_jogada, db_memoria;

    fluxo_dados_quiz #(
        .N_RODADAS(N_RODADAS),
        .T_MAX    (T_MAX),
        .TW       (TW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .botoes           (botoes),
        .zeraR            (zeraR),
        .zeraRod          (zeraRod),
        .zeraA            (zeraA),
        .zeraM            (zeraM),
        .zeraI            (zeraI),
        .registraR        (registraR),
        .registraM        (registraM),
        .contaRod         (contaRod),
        .contaA           (contaA),
        .contaI           (contaI),
        .jogada_feita     (jogada_feita),
        .botaoIgualMemoria(botaoIgualMemoria),
        .rodadaIgualFinal (rodadaIgualFinal),
        .timeout          (timeout),
        .db_rodada        (db_rodada),
        .db_acertos       (db_acertos),
        .db_jogada        (db_jogada),
        .db_memoria       (db_memoria)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, kept as plain integers.
    int m_rod, m_acc, m_r, m_m, m_i, m_j, m_jf;
    int p1, p2, p3;  // button value seen at the last 1, 2, 3 edges

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rom_exp(input int a);
        return (a < N_RODADAS) ? (1 << (a % 4)) : 0;
    endfunction

    task automatic model_clear();
        m_rod = 0; m_acc = 0; m_r = 0; m_m = 0; m_i = 0; m_j = 0; m_jf = 0;
        p1 = 0; p2 = 0; p3 = 0;
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".rodada"},  32'(db_rodada),  32'(m_rod));
        check_eq({ph, ".acertos"}, 32'(db_acertos), 32'(m_acc));
        check_eq({ph, ".jogada"},  32'(db_jogada),  32'(m_r));
        check_eq({ph, ".memoria"}, 32'(db_memoria), 32'(m_m));
        check_eq({ph, ".jf"},      32'(jogada_feita), 32'(m_jf));
        check_eq({ph, ".igual"},   32'(botaoIgualMemoria), 32'(m_r == m_m));
        check_eq({ph, ".final"},   32'(rodadaIgualFinal), 32'(m_rod == N_RODADAS));
        check_eq({ph, ".timeout"}, 32'(timeout), 32'(m_i == T_MAX - 1));
    endtask

    task automatic clr_strobes();
        zeraR = 0; zeraRod = 0; zeraA = 0; zeraM = 0; zeraI = 0;
        registraR = 0; registraM = 0; contaRod = 0; contaA = 0; contaI = 0;
    endtask

    // One clock: advance the model with the inputs applied, then check #1 later.
    task automatic tick(input string ph);
        int rod_old;
        @(posedge clock);
        rod_old = m_rod;
        if (zeraR) m_r = 0; else if (registraR) m_r = m_j;
        if (zeraM) m_m = 0; else if (registraM) m_m = rom_exp(rod_old);
        if (zeraRod) m_rod = 0; else if (contaRod) m_rod = (m_rod + 1) % 16;
        if (zeraA) m_acc = 0; else if (contaA && m_acc < 15) m_acc = m_acc + 1;
        if (zeraI) m_i = 0; else if (contaI && m_i < T_MAX - 1) m_i = m_i + 1;
        // Pulse three edges after the button value first goes non-zero.
        m_jf = (p2 != 0 && p3 == 0) ? 1 : 0;
        if (m_jf != 0) m_j = p2;
        p3 = p2; p2 = p1; p1 = int'(botoes);
        #1;
        check_all(ph);
    endtask

    // Called at posedge+1: assert reset, check the clear before the next edge.
    task automatic do_reset(input string ph);
        reset = 1'b0;
        #2;
        model_clear();
        check_all(ph);
        #4;
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        int r;
        clr_strobes();
        botoes = 4'd0;
        reset  = 1'b0;
        model_clear();
        #12;
        check_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 5; i++) tick("idle");

        // Round 1: load M=ROM[0], press button A.
        registraM = 1; contaRod = 1;
        tick("prox1");
        clr_strobes();
        botoes = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            tick("pressA");
            check_eq("jf_latency3", 32'(jogada_feita), 32'(i == 3));
        end
        botoes = 4'b0000;
        registraR = 1;
        tick("regR1");
        registraR = 0;
        check_eq("r1_jogada",  32'(db_jogada), 32'h1);
        check_eq("r1_memoria", 32'(db_memoria), 32'h1);
        check_eq("r1_igual",   32'(botaoIgualMemoria), 32'h1);

        // Round 2: M=0010, wrong single press then multi-hot press.
        registraM = 1; contaRod = 1;
        tick("prox2");
        clr_strobes();
        for (int i = 0; i < 4; i++) tick("release");
        botoes = 4'b0100;
        for (int i = 0; i < 6; i++) tick("pressC");
        registraR = 1;
        tick("regR2");
        registraR = 0;
        check_eq("r2_memoria", 32'(db_memoria), 32'h2);
        check_eq("r2_igual",   32'(botaoIgualMemoria), 32'h0);
        botoes = 4'b0000;
        for (int i = 0; i < 4; i++) tick("release");
        botoes = 4'b0110;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick("hold");
            if (jogada_feita) pulses++;
        end
        check_eq("hold_one_pulse", 32'(pulses), 32'd1);
        registraR = 1;
        tick("regR3");
        registraR = 0;
        check_eq("multi_jogada", 32'(db_jogada), 32'h6);
        check_eq("multi_igual",  32'(botaoIgualMemoria), 32'h0);
        botoes = 4'b0000;

        // Round counter to N_RODADAS, then clear beating increment.
        zeraRod = 1;
        tick("zrod");
        zeraRod = 0;
        registraM = 1; contaRod = 1;
        for (int k = 1; k <= 10; k++) begin
            tick("rounds");
            check_eq("final_flag", 32'(rodadaIgualFinal), 32'(k == 10));
        end
        check_eq("rodada10", 32'(db_rodada), 32'd10);
        registraM = 0;
        zeraRod = 1;
        tick("zrod_vs_conta");
        clr_strobes();
        check_eq("rodada_cleared", 32'(db_rodada), 32'd0);

        // Timer saturation at T_MAX-1.
        zeraI = 1;
        tick("zI");
        zeraI = 0; contaI = 1;
        for (int k = 1; k <= 10; k++) begin
            tick("timer");
            check_eq("timeout_rise", 32'(timeout), 32'(k >= 7));
        end
        zeraI = 1;
        tick("zI2");
        zeraI = 0;
        check_eq("timeout_clr", 32'(timeout), 32'd0);
        contaI = 0;

        // Hit counter saturation and asynchronous reset mid-count.
        contaA = 1;
        for (int k = 0; k < 20; k++) tick("acertos");
        check_eq("acertos_sat", 32'(db_acertos), 32'd15);
        botoes = 4'b0001;
        tick("acc_hold");
        do_reset("async_rst");
        check_eq("rst_acertos", 32'(db_acertos), 32'd0);
        check_eq("rst_rodada",  32'(db_rodada),  32'd0);
        botoes = 4'b0000;
        clr_strobes();

        // Randomized phase against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) begin
                r = int'($urandom_range(9));
                case (r)
                    0, 1, 2: botoes = 4'b0000;
                    3:       botoes = 4'b0001;
                    4:       botoes = 4'b0010;
                    5:       botoes = 4'b0100;
                    6:       botoes = 4'b1000;
                    default: botoes = 4'($urandom);
                endcase
            end
            zeraR     = ($urandom_range(15) == 0);
            zeraRod   = ($urandom_range(15) == 0);
            zeraA     = ($urandom_range(15) == 0);
            zeraM     = ($urandom_range(15) == 0);
            zeraI     = ($urandom_range(15) == 0);
            registraR = ($urandom_range(2) == 0);
            registraM = ($urandom_range(2) == 0);
            contaRod  = ($urandom_range(2) == 0);
            contaA    = ($urandom_range(2) == 0);
            contaI    = ($urandom_range(7) != 0);
            tick("rand");
            if (c == 300) begin
                botoes = 4'b0000;
                do_reset("rand_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
